// File: rtl/lcd_nibble_controller_pkg.sv
// rtl/lcd_nibble_controller_pkg.sv - shared types and constants for the HD44780 nibble controller
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWR   = 3'd0,
        S_SETUP = 3'd1,
        S_EHIGH = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4,
        S_IDLE  = 3'd5
    } lcd_state_e;

    typedef enum logic [1:0] {
        IG_4MS   = 2'd0,
        IG_100US = 2'd1,
        IG_40US  = 2'd2
    } init_gap_e;

    localparam int DEF_CNT_W   = 20;
    localparam int DEF_T_PWR   = 750000;
    localparam int DEF_T_4MS   = 205000;
    localparam int DEF_T_100US = 5000;
    localparam int DEF_T_40US  = 2000;
    localparam int DEF_T_LONG  = 82000;
    localparam int DEF_T_SETUP = 2;
    localparam int DEF_T_EHIGH = 12;
    localparam int DEF_T_HOLD  = 1;
    localparam int DEF_T_GAP   = 50;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Power-on 4-bit entry: three 0x3 wake-ups, then 0x2 to switch the bus width.
    function automatic logic [3:0] init_nibble(input logic [1:0] step);
        return (step == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    function automatic init_gap_e init_gap(input logic [1:0] step);
        case (step)
            2'd0:    return IG_4MS;
            2'd1:    return IG_100US;
            default: return IG_40US;
        endcase
    endfunction

endpackage

// File: rtl/lcd_nibble_controller_if.sv
// rtl/lcd_nibble_controller_if.sv - CPU-side nibble write port of the LCD controller
interface lcd_nibble_controller_if;
    logic [3:0] iData;
    logic       iRS;
    logic       iWriteEN;
    logic       oBusy;
    logic       oInitDone;
    logic       oOverrun;

    modport master (
        output iData, iRS, iWriteEN,
        input  oBusy, oInitDone, oOverrun
    );

    modport slave (
        input  iData, iRS, iWriteEN,
        output oBusy, oInitDone, oOverrun
    );
endinterface

// File: rtl/lcd_nibble_controller_timer.sv
// rtl/lcd_nibble_controller_timer.sv - loadable down-counter; a load of N gives N cycles before done
module lcd_delay_timer #(
    parameter int                   P_CNT_W   = 20,
    parameter logic [P_CNT_W-1:0]   P_RST_VAL = '1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               load_i,
    input  logic [P_CNT_W-1:0] load_val_i,
    output logic               done_o
);

    logic [P_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= P_RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Done on the last cycle, so the counter reaches 0 as the state is left.
    assign done_o = (cnt_q == P_CNT_W'(1));

endmodule

// File: rtl/lcd_nibble_controller.sv
// rtl/lcd_nibble_controller.sv - CPU nibble port to 4-bit HD44780 LCD with power-on init
module lcd_nibble_controller
    import lcd_pkg::*;
#(
    parameter int P_CNT_W   = DEF_CNT_W,
    parameter int P_T_PWR   = DEF_T_PWR,
    parameter int P_T_4MS   = DEF_T_4MS,
    parameter int P_T_100US = DEF_T_100US,
    parameter int P_T_40US  = DEF_T_40US,
    parameter int P_T_LONG  = DEF_T_LONG,
    parameter int P_T_SETUP = DEF_T_SETUP,
    parameter int P_T_EHIGH = DEF_T_EHIGH,
    parameter int P_T_HOLD  = DEF_T_HOLD,
    parameter int P_T_GAP   = DEF_T_GAP
) (
    input  logic                   Clock,
    input  logic                   Reset,
    lcd_nibble_controller_if.slave cpu,
    output logic                   oLCD_E,
    output logic                   oLCD_RS,
    output logic                   oLCD_RW,
    output logic [3:0]             oLCD_D
);

    localparam logic [P_CNT_W-1:0] T_PWR   = P_CNT_W'(P_T_PWR);
    localparam logic [P_CNT_W-1:0] T_4MS   = P_CNT_W'(P_T_4MS);
    localparam logic [P_CNT_W-1:0] T_100US = P_CNT_W'(P_T_100US);
    localparam logic [P_CNT_W-1:0] T_40US  = P_CNT_W'(P_T_40US);
    localparam logic [P_CNT_W-1:0] T_LONG  = P_CNT_W'(P_T_LONG);
    localparam logic [P_CNT_W-1:0] T_SETUP = P_CNT_W'(P_T_SETUP);
    localparam logic [P_CNT_W-1:0] T_EHIGH = P_CNT_W'(P_T_EHIGH);
    localparam logic [P_CNT_W-1:0] T_HOLD  = P_CNT_W'(P_T_HOLD);
    localparam logic [P_CNT_W-1:0] T_GAP   = P_CNT_W'(P_T_GAP);

    lcd_state_e state_q, state_d;
    logic [1:0] step_q, step_d;
    logic       phase_low_q, phase_low_d;
    logic       cur_low_q, cur_low_d;
    logic [3:0] hi_nib_q, hi_nib_d;
    logic [3:0] d_q, d_d;
    logic       rs_q, rs_d;
    logic       init_done_q, init_done_d;
    logic       overrun_q, overrun_d;
    logic       wen_prev_q;

    logic               wr_edge;
    logic               is_long;
    logic               tmr_load;
    logic               tmr_done;
    logic [P_CNT_W-1:0] tmr_val;
    logic [P_CNT_W-1:0] gap_val;

    lcd_delay_timer #(
        .P_CNT_W   (P_CNT_W),
        .P_RST_VAL (T_PWR)
    ) u_timer (
        .Clock      (Clock),
        .Reset      (Reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // iWriteEN is a level held through the CPU's sync spin; only its rising edge is a write.
    assign wr_edge = cpu.iWriteEN & ~wen_prev_q;
    assign is_long = ~rs_q & (({hi_nib_q, d_q} == CMD_CLEAR) | ({hi_nib_q, d_q} == CMD_HOME));

    always_comb begin
        gap_val = T_GAP;
        if (!init_done_q) begin
            case (init_gap(step_q))
                IG_4MS:   gap_val = T_4MS;
                IG_100US: gap_val = T_100US;
                default:  gap_val = T_40US;
            endcase
        end else if (cur_low_q) begin
            gap_val = is_long ? T_LONG : T_40US;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        phase_low_d = phase_low_q;
        cur_low_d   = cur_low_q;
        hi_nib_d    = hi_nib_q;
        d_d         = d_q;
        rs_d        = rs_q;
        init_done_d = init_done_q;
        overrun_d   = overrun_q;
        tmr_load    = 1'b0;
        tmr_val     = T_SETUP;

        if (wr_edge && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_PWR: begin
                if (tmr_done) begin
                    state_d  = S_SETUP;
                    step_d   = 2'd0;
                    d_d      = init_nibble(2'd0);
                    rs_d     = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = T_SETUP;
                end
            end
            S_SETUP: begin
                if (tmr_done) begin
                    state_d  = S_EHIGH;
                    tmr_load = 1'b1;
                    tmr_val  = T_EHIGH;
                end
            end
            S_EHIGH: begin
                if (tmr_done) begin
                    state_d  = S_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = T_HOLD;
                end
            end
            S_HOLD: begin
                if (tmr_done) begin
                    state_d  = S_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = gap_val;
                end
            end
            S_GAP: begin
                if (tmr_done) begin
                    if (init_done_q) begin
                        state_d = S_IDLE;
                    end else if (step_q == 2'd3) begin
                        state_d     = S_IDLE;
                        init_done_d = 1'b1;
                        phase_low_d = 1'b0;
                    end else begin
                        state_d  = S_SETUP;
                        step_d   = step_q + 2'd1;
                        d_d      = init_nibble(step_q + 2'd1);
                        tmr_load = 1'b1;
                        tmr_val  = T_SETUP;
                    end
                end
            end
            S_IDLE: begin
                if (wr_edge) begin
                    state_d     = S_SETUP;
                    d_d         = cpu.iData;
                    rs_d        = cpu.iRS;
                    cur_low_d   = phase_low_q;
                    phase_low_d = ~phase_low_q;
                    if (!phase_low_q) begin
                        hi_nib_d = cpu.iData;
                    end
                    tmr_load = 1'b1;
                    tmr_val  = T_SETUP;
                end
            end
            default: begin
                state_d = S_PWR;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_PWR;
            step_q      <= 2'd0;
            phase_low_q <= 1'b0;
            cur_low_q   <= 1'b0;
            hi_nib_q    <= 4'h0;
            d_q         <= 4'h0;
            rs_q        <= 1'b0;
            init_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            wen_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            phase_low_q <= phase_low_d;
            cur_low_q   <= cur_low_d;
            hi_nib_q    <= hi_nib_d;
            d_q         <= d_d;
            rs_q        <= rs_d;
            init_done_q <= init_done_d;
            overrun_q   <= overrun_d;
            wen_prev_q  <= cpu.iWriteEN;
        end
    end

    // E comes straight from the state register so an async reset drops it at once.
    assign oLCD_E        = (state_q == S_EHIGH);
    assign oLCD_RS       = rs_q;
    assign oLCD_RW       = 1'b0;
    assign oLCD_D        = d_q;
    assign cpu.oBusy     = (state_q != S_IDLE);
    assign cpu.oInitDone = init_done_q;
    assign cpu.oOverrun  = overrun_q;

endmodule

// File: tb/tb_lcd_nibble_controller.sv
// tb/tb_lcd_nibble_controller.sv - self-checking bench for lcd_nibble_controller
module tb_lcd_nibble_controller;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       oLCD_E, oLCD_RS, oLCD_RW;
    logic [3:0] oLCD_D;

    lcd_nibble_controller_if cpu ();

    lcd_nibble_controller #(
        .P_CNT_W   (20),
        .P_T_PWR   (20),
        .P_T_4MS   (10),
        .P_T_100US (6),
        .P_T_40US  (4),
        .P_T_LONG  (9),
        .P_T_SETUP (2),
        .P_T_EHIGH (3),
        .P_T_HOLD  (1),
        .P_T_GAP   (2)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .cpu     (cpu.slave),
        .oLCD_E  (oLCD_E),
        .oLCD_RS (oLCD_RS),
        .oLCD_RW (oLCD_RW),
        .oLCD_D  (oLCD_D)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int         cyc;
        logic [3:0] d;
        logic       rs;
    } rise_t;

    typedef struct {
        logic       rs;
        logic [3:0] d;
        int         busy;
    } vec_t;

    rise_t rises[$];
    int    falls[$];
    int    cyc;
    int    busy_fall;
    logic  e_prev;
    logic  busy_prev;
    int    n_total = 0;
    int    n_pass  = 0;
    vec_t  vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
        if (oLCD_E && !e_prev) rises.push_back('{cyc, oLCD_D, oLCD_RS});
        if (!oLCD_E && e_prev) falls.push_back(cyc);
        if (busy_prev && !cpu.oBusy) busy_fall = cyc;
        e_prev    = oLCD_E;
        busy_prev = cpu.oBusy;
    endtask

    task automatic clear_mon();
        rises.delete();
        falls.delete();
        busy_fall = -1;
    endtask

    task automatic release_reset();
        Reset = 1'b1;
        cpu.iWriteEN = 1'b0;
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Reset     = 1'b0;
        cyc       = 0;
        e_prev    = 1'b0;
        busy_prev = 1'b1;
        clear_mon();
    endtask

    // inj > 0 raises iWriteEN so that its edge is sampled at clock inj.
    task automatic run_init(input string tag, input int inj);
        int n = 0;
        while (busy_fall < 0 && n < 200) begin
            cpu.iWriteEN = (inj > 0 && cyc == inj - 1);
            tick();
            n++;
        end
        cpu.iWriteEN = 1'b0;
        check({tag, "_init_timeout"}, int'(busy_fall >= 0), 1);
        check({tag, "_init_pulses"}, rises.size(), 4);
        if (rises.size() == 4 && falls.size() >= 4) begin
            check({tag, "_first_rise"}, rises[0].cyc, 22);
            check({tag, "_step01"}, rises[1].cyc - rises[0].cyc, 16);
            check({tag, "_step12"}, rises[2].cyc - rises[1].cyc, 12);
            check({tag, "_step23"}, rises[3].cyc - rises[2].cyc, 10);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("%s_init_d%0d", tag, i), rises[i].d, (i == 3) ? 2 : 3);
                check($sformatf("%s_init_rs%0d", tag, i), rises[i].rs, 0);
                check($sformatf("%s_init_w%0d", tag, i), falls[i] - rises[i].cyc, 3);
            end
        end
        check({tag, "_busy_fall"}, busy_fall, 68);
        check({tag, "_init_done"}, cpu.oInitDone, 1);
        check({tag, "_overrun"}, cpu.oOverrun, (inj > 0) ? 1 : 0);
    endtask

    // Writes one nibble; k is the clock at which the edge is sampled.
    task automatic do_write(input logic rs, input logic [3:0] d, input int hold, output int k);
        int n = 0;
        clear_mon();
        cpu.iRS      = rs;
        cpu.iData    = d;
        cpu.iWriteEN = 1'b1;
        tick();
        k = cyc;
        for (int i = 1; i < hold; i++) tick();
        cpu.iWriteEN = 1'b0;
        while (cpu.oBusy && n < 60) begin
            tick();
            n++;
        end
        check("write_timeout", cpu.oBusy, 0);
    endtask

    task automatic check_write(input string tag, input vec_t v, input int k);
        check({tag, "_pulses"}, rises.size(), 1);
        if (rises.size() >= 1 && falls.size() >= 1) begin
            check({tag, "_rise"}, rises[0].cyc - k, 2);
            check({tag, "_d"}, rises[0].d, v.d);
            check({tag, "_rs"}, rises[0].rs, v.rs);
            check({tag, "_width"}, falls[0] - rises[0].cyc, 3);
        end
        check({tag, "_busy"}, busy_fall - k, v.busy);
    endtask

    initial begin
        int   k;
        vec_t v;
        vecs[0]  = '{1'b1, 4'h4, 8};
        vecs[1]  = '{1'b1, 4'h1, 10};
        vecs[2]  = '{1'b0, 4'h0, 8};
        vecs[3]  = '{1'b0, 4'h1, 15};
        vecs[4]  = '{1'b0, 4'h0, 8};
        vecs[5]  = '{1'b0, 4'h2, 15};
        vecs[6]  = '{1'b1, 4'h0, 8};
        vecs[7]  = '{1'b1, 4'h1, 10};
        vecs[8]  = '{1'b0, 4'h3, 8};
        vecs[9]  = '{1'b0, 4'h8, 10};
        vecs[10] = '{1'b0, 4'h1, 8};
        vecs[11] = '{1'b0, 4'h0, 10};

        cpu.iData    = 4'h0;
        cpu.iRS      = 1'b0;
        cpu.iWriteEN = 1'b0;
        #12;
        check("rst_busy", cpu.oBusy, 1);
        check("rst_initdone", cpu.oInitDone, 0);
        check("rst_overrun", cpu.oOverrun, 0);
        check("rst_e", oLCD_E, 0);
        check("rst_rs", oLCD_RS, 0);
        check("rst_rw", oLCD_RW, 0);
        check("rst_d", oLCD_D, 0);

        release_reset();
        run_init("a", 0);

        for (int i = 0; i < 12; i++) begin
            do_write(vecs[i].rs, vecs[i].d, 1, k);
            check_write($sformatf("vec%0d", i), vecs[i], k);
        end

        // Level strobe held 5 cycles: one pulse, no overrun.
        v = '{1'b1, 4'h7, 8};
        do_write(v.rs, v.d, 5, k);
        check_write("level_hi", v, k);
        check("level_overrun", cpu.oOverrun, 0);
        v = '{1'b1, 4'h2, 10};
        do_write(v.rs, v.d, 5, k);
        check_write("level_lo", v, k);

        // Second edge while E is high is dropped.
        clear_mon();
        cpu.iRS = 1'b1; cpu.iData = 4'h5; cpu.iWriteEN = 1'b1;
        tick(); k = cyc;
        cpu.iWriteEN = 1'b0;
        tick(); tick();
        check("ovr_e_high", oLCD_E, 1);
        cpu.iData = 4'hA; cpu.iWriteEN = 1'b1;
        tick();
        check("ovr_flag", cpu.oOverrun, 1);
        cpu.iWriteEN = 1'b0;
        for (int i = 0; i < 20 && cpu.oBusy; i++) tick();
        check("ovr_pulses", rises.size(), 1);
        if (rises.size() >= 1) check("ovr_d", rises[0].d, 4'h5);
        check("ovr_busy", busy_fall - k, 8);

        // Async reset in the middle of E high.
        clear_mon();
        cpu.iRS = 1'b1; cpu.iData = 4'h6; cpu.iWriteEN = 1'b1;
        tick();
        cpu.iWriteEN = 1'b0;
        tick(); tick();
        check("ar_e_before", oLCD_E, 1);
        Reset = 1'b1;
        #1;
        check("ar_e_drop", oLCD_E, 0);
        check("ar_busy", cpu.oBusy, 1);
        check("ar_overrun", cpu.oOverrun, 0);
        check("ar_initdone", cpu.oInitDone, 0);
        release_reset();
        run_init("b", 0);

        // Edge on the very clock busy falls is dropped.
        clear_mon();
        cpu.iRS = 1'b1; cpu.iData = 4'h4; cpu.iWriteEN = 1'b1;
        tick(); k = cyc;
        cpu.iWriteEN = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        cpu.iWriteEN = 1'b1;
        tick();
        check("sim_busy", cpu.oBusy, 0);
        check("sim_overrun", cpu.oOverrun, 1);
        check("sim_busy_fall", busy_fall - k, 8);
        cpu.iWriteEN = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("sim_pulses", rises.size(), 1);
        check("sim_idle", cpu.oBusy, 0);

        // Edge during init sets overrun without disturbing the sequence.
        release_reset();
        run_init("c", 10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
